sha256_w_sched_ctrl: RTL and testbench



---
 rtl/sha256_pkg.sv | 24 ++
 rtl/sha256_w_next.sv | 19 +
 rtl/sha256_w_sched_ctrl.sv | 101 ++++++++++
 tb/tb_sha256_w_sched_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message-schedule slice.
// Provides the word/block widths, the small-sigma functions used by the
// schedule expansion, and the controller state encoding.
package sha256_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BLK_W  = 512;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } sched_state_e;

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [WORD_W-1:0] sha256_s0(input logic [WORD_W-1:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [WORD_W-1:0] sha256_s1(input logic [WORD_W-1:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_w_next.sv
// Combinational SHA-256 schedule expansion step.
// Ports:
//   w_m2, w_m7, w_m15, w_m16 : W[t-2], W[t-7], W[t-15], W[t-16]
//   w_next                   : W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] mod 2^32
module sha256_w_next
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] w_m2,
  input  logic [WORD_W-1:0] w_m7,
  input  logic [WORD_W-1:0] w_m15,
  input  logic [WORD_W-1:0] w_m16,
  output logic [WORD_W-1:0] w_next
);

  always_comb begin
    w_next = sha256_s1(w_m2) + w_m7 + sha256_s0(w_m15) + w_m16;
  end

endmodule

// File: rtl/sha256_w_sched_ctrl.sv
// SHA-256 message-schedule sequencer.
// Accepts one 512-bit block (valid/ready) and streams W0..W(ROUNDS-1), one
// word per accepted beat, from a 16-word rolling window.
// Ports:
//   CLK, RST           : clock, asynchronous active-high reset
//   clear              : synchronous abort, highest priority
//   blk_valid/ready    : block handshake; blk_data holds W0 in [511:480] .. W15 in [31:0]
//   w_valid/ready      : word handshake; w_data = W[w_idx], w_last marks idx ROUNDS-1
//   busy               : a block is in progress
module sha256_w_sched_ctrl
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clear,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic [BLK_W-1:0]  blk_data,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_data,
  output logic [5:0]        w_idx,
  output logic              w_last,
  output logic              busy
);

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  sched_state_e      state_q, state_d;
  logic [WORD_W-1:0] win_q [16];
  logic [WORD_W-1:0] win_d [16];
  logic [5:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] w_new;
  logic              at_last;
  logic              blk_fire;

  sha256_w_next u_w_next (
    .w_m2   (win_q[14]),
    .w_m7   (win_q[9]),
    .w_m15  (win_q[1]),
    .w_m16  (win_q[0]),
    .w_next (w_new)
  );

  assign at_last = (state_q == ST_RUN) && (cnt_q == LAST_IDX);

  // The last beat reopens the block port so the next block follows with no bubble.
  assign blk_ready = !clear && ((state_q == ST_IDLE) || (at_last && w_ready));
  assign blk_fire  = blk_valid && blk_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (blk_fire) begin
      for (int unsigned i = 0; i < 16; i++) begin
        win_d[i] = blk_data[BLK_W-1-WORD_W*i -: WORD_W];
      end
      cnt_d   = '0;
      state_d = ST_RUN;
    end else if ((state_q == ST_RUN) && w_ready) begin
      if (at_last) begin
        state_d = ST_IDLE;
      end else begin
        for (int unsigned i = 0; i < 15; i++) begin
          win_d[i] = win_q[i+1];
        end
        win_d[15] = w_new;
        cnt_d     = cnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int unsigned i = 0; i < 16; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  assign w_valid = (state_q == ST_RUN);
  assign busy    = (state_q == ST_RUN);
  assign w_data  = win_q[0];
  assign w_idx   = cnt_q;
  assign w_last  = at_last;

endmodule

// File: tb/tb_sha256_w_sched_ctrl.sv
module tb_sha256_w_sched_ctrl;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         clear = 1'b0;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         w_valid;
  logic         w_ready = 1'b0;
  logic [31:0]  w_data;
  logic [5:0]   w_idx;
  logic         w_last;
  logic         busy;

  logic         blk_valid2 = 1'b0;
  logic         blk_ready2;
  logic         w_valid2;
  logic         w_ready2 = 1'b0;
  logic [31:0]  w_data2;
  logic [5:0]   w_idx2;
  logic         w_last2;
  logic         busy2;

  int checks = 0;
  int failures = 0;

  logic [511:0] blk_a, blk_b;
  logic [31:0]  gold_a [64];
  logic [31:0]  gold_b [64];
  logic [31:0]  gtmp   [64];
  logic [31:0]  gseq   [128];
  logic [31:0]  cap    [128];

  always #5 CLK = ~CLK;

  sha256_w_sched_ctrl #(.ROUNDS(64)) dut (
    .CLK(CLK), .RST(RST), .clear(clear),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .w_idx(w_idx), .w_last(w_last), .busy(busy)
  );

  sha256_w_sched_ctrl #(.ROUNDS(17)) dut17 (
    .CLK(CLK), .RST(RST), .clear(clear),
    .blk_valid(blk_valid2), .blk_ready(blk_ready2), .blk_data(blk_data),
    .w_valid(w_valid2), .w_ready(w_ready2), .w_data(w_data2),
    .w_idx(w_idx2), .w_last(w_last2), .busy(busy2)
  );

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  task automatic expand(input logic [511:0] blk);
    for (int t = 0; t < 16; t++) gtmp[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      gtmp[t] = ref_s1(gtmp[t-2]) + gtmp[t-7] + ref_s0(gtmp[t-15]) + gtmp[t-16];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [511:0] blk);
    @(negedge CLK);
    blk_valid = 1'b1;
    blk_data  = blk;
    #1;
    chk("send_blk_ready", 32'(blk_ready), 32'd1);
    chk("send_w_valid_idle", 32'(w_valid), 32'd0);
  endtask

  // Receive n words against gseq; rnd toggles w_ready, hold keeps blk_valid
  // high with blk_b presented until the first block's last beat.
  task automatic recv(input int n, input bit rnd, input bit hold);
    int got = 0;
    int budget = 2000;
    bit pstall = 1'b0;
    logic [31:0] pd = '0;
    logic [5:0]  pi = '0;
    while (got < n && budget > 0) begin
      @(negedge CLK);
      budget--;
      w_ready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      blk_valid = hold && (got < 64);
      if (hold) blk_data = blk_b;
      #1;
      if (pstall) begin
        chk("stall_data", w_data, pd);
        chk("stall_idx", 32'(w_idx), 32'(pi));
      end
      chk("w_valid", 32'(w_valid), 32'd1);
      chk("w_idx", 32'(w_idx), 32'(got % 64));
      chk("w_data", w_data, gseq[got]);
      chk("w_last", 32'(w_last), 32'((got % 64) == 63));
      chk("blk_ready_run", 32'(blk_ready), 32'(w_ready && ((got % 64) == 63)));
      cap[got] = w_data;
      pstall = w_valid && !w_ready;
      pd = w_data;
      pi = w_idx;
      if (w_valid && w_ready) got++;
    end
    if (budget == 0) chk("recv_timeout", 32'(got), 32'(n));
  endtask

  task automatic expect_idle(input string tag);
    @(negedge CLK);
    blk_valid = 1'b0;
    #1;
    chk({tag, "_w_valid"}, 32'(w_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    blk_a = '0;
    blk_a[511:480] = 32'h61626380;
    blk_a[31:0]    = 32'h00000018;
    for (int i = 0; i < 16; i++)
      blk_b[511-32*i -: 32] = (32'h9e3779b9 * 32'(i + 1)) ^ 32'h5a5a0000;
    expand(blk_a);
    for (int t = 0; t < 64; t++) gold_a[t] = gtmp[t];
    expand(blk_b);
    for (int t = 0; t < 64; t++) gold_b[t] = gtmp[t];

    // Reset state
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_w_valid", 32'(w_valid), 32'd0);
    chk("rst_w_data", w_data, 32'd0);
    chk("rst_w_idx", 32'(w_idx), 32'd0);
    chk("rst_w_last", 32'(w_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("post_rst_blk_ready", 32'(blk_ready), 32'd1);

    // "abc" block, full throughput
    for (int t = 0; t < 64; t++) gseq[t] = gold_a[t];
    send(blk_a);
    recv(64, 1'b0, 1'b0);
    chk("abc_w16", cap[16], 32'h61626380);
    chk("abc_w17", cap[17], 32'h000f0000);
    expect_idle("abc_end");

    // Random backpressure
    send(blk_a);
    recv(64, 1'b1, 1'b0);
    expect_idle("bp_end");

    // Back-to-back blocks, no gap
    for (int t = 0; t < 64; t++) begin
      gseq[t] = gold_a[t];
      gseq[t+64] = gold_b[t];
    end
    send(blk_a);
    recv(128, 1'b0, 1'b1);
    expect_idle("b2b_end");

    // clear at idx 20
    for (int t = 0; t < 64; t++) gseq[t] = gold_a[t];
    send(blk_a);
    recv(20, 1'b0, 1'b0);
    @(negedge CLK);
    clear = 1'b1;
    blk_valid = 1'b1;
    blk_data = blk_b;
    w_ready = 1'b1;
    #1;
    chk("clr_blk_ready", 32'(blk_ready), 32'd0);
    chk("clr_w_idx", 32'(w_idx), 32'd20);
    chk("clr_w_data", w_data, gold_a[20]);
    @(negedge CLK);
    clear = 1'b0;
    blk_valid = 1'b0;
    #1;
    chk("clr_w_valid_after", 32'(w_valid), 32'd0);
    chk("clr_busy_after", 32'(busy), 32'd0);
    for (int t = 0; t < 64; t++) gseq[t] = gold_b[t];
    send(blk_b);
    recv(64, 1'b0, 1'b0);
    expect_idle("clr_restart_end");

    // RST at idx 40
    for (int t = 0; t < 64; t++) gseq[t] = gold_a[t];
    send(blk_a);
    recv(40, 1'b0, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("arst_w_valid", 32'(w_valid), 32'd0);
    chk("arst_w_data", w_data, 32'd0);
    chk("arst_w_idx", 32'(w_idx), 32'd0);
    chk("arst_w_last", 32'(w_last), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("arst_rel_blk_ready", 32'(blk_ready), 32'd1);
    chk("arst_rel_w_valid", 32'(w_valid), 32'd0);
    for (int t = 0; t < 64; t++) gseq[t] = gold_b[t];
    send(blk_b);
    recv(64, 1'b0, 1'b0);
    expect_idle("arst_restart_end");

    // ROUNDS=17 instance
    @(negedge CLK);
    blk_valid2 = 1'b1;
    blk_data = blk_a;
    #1;
    chk("r17_blk_ready", 32'(blk_ready2), 32'd1);
    for (int k = 0; k < 17; k++) begin
      @(negedge CLK);
      blk_valid2 = 1'b0;
      w_ready2 = 1'b1;
      #1;
      chk("r17_w_valid", 32'(w_valid2), 32'd1);
      chk("r17_w_idx", 32'(w_idx2), 32'(k));
      chk("r17_w_data", w_data2, gold_a[k]);
      chk("r17_w_last", 32'(w_last2), 32'(k == 16));
    end
    @(negedge CLK);
    #1;
    chk("r17_end_w_valid", 32'(w_valid2), 32'd0);
    chk("r17_end_busy", 32'(busy2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
